cpu_ctrl_fsm: RTL
=================

Name: cpu_ctrl_fsm

Overview:
- Sequencing controller for the 5-bit-address accumulator CPU.
- Steps each instruction through 8 phases: fetch, decode, operand fetch, execute and writeback.
- Drives PC increment/load, IR load, accumulator load, and memory read/write/address-select.
- Handles the HLT, SKZ and JMP control flow, and stalls on slow memory.

Parameters:
- STALL_EN, 1, 1 = honour mem_rdy in fetch phases; 0 = mem_rdy ignored (single-cycle memory).

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  synchronous, active-low reset
- opcode  input  3  instruction opcode from IR[7:5]
- zero  input  1  accumulator-zero flag from ALU
- mem_rdy  input  1  memory data valid; used only in INST_FETCH / OP_FETCH
- run  input  1  one-cycle pulse that resumes execution from HALTED
- sel  output  1  address mux select: 1 = PC, 0 = IR operand
- rd  output  1  memory read enable
- ld_ir  output  1  load instruction register
- inc_pc  output  1  PC increment enable (to PC en)
- ld_pc  output  1  PC parallel load (to PC load)
- ld_ac  output  1  load accumulator
- wr  output  1  memory write strobe
- data_e  output  1  accumulator drives data bus
- halt  output  1  high while in HALTED
- phase  output  3  current phase, for debug/trace

Behaviour:
- Opcodes: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- ALUOP = ADD | AND | XOR | LDA.
- Phases: INST_ADDR=0, INST_FETCH=1, INST_LOAD=2, IDLE=3, OP_ADDR=4, OP_FETCH=5, ALU_OP=6, STORE=7, plus a separate HALTED state.
- Normal sequence: each phase advances to the next every cycle; STORE wraps to INST_ADDR.
- Stall: with STALL_EN=1, INST_FETCH and OP_FETCH hold while mem_rdy=0. Outputs stay at that phase's values; phase advances on the first cycle mem_rdy=1.
- Outputs are a combinational decode of (phase, opcode, zero); only the phase/halted state is registered.
- Output decode per phase (any output not listed is 0):
  - INST_ADDR: sel=1.
  - INST_FETCH: sel=1, rd=1.
  - INST_LOAD: sel=1, rd=1, ld_ir=1.
  - IDLE: sel=1, rd=1, ld_ir=1.
  - OP_ADDR: inc_pc=1; halt=1 if opcode==HLT.
  - OP_FETCH: rd=ALUOP.
  - ALU_OP: rd=ALUOP; inc_pc=(opcode==SKZ && zero); ld_pc=(opcode==JMP); data_e=(opcode==STO).
  - STORE: rd=ALUOP; ld_ac=ALUOP; ld_pc=(opcode==JMP); wr=(opcode==STO); data_e=(opcode==STO).
- HLT handling: in OP_ADDR with opcode==HLT, the next state is HALTED (PC has already been incremented).
- HALTED outputs: halt=1, phase=OP_ADDR encoding, all other outputs 0.
- Leaving HALTED: run=1 moves the FSM to INST_ADDR on the next edge. run is ignored in every other state.
- ld_pc and inc_pc must never be asserted in the same cycle: SKZ and JMP are mutually exclusive by opcode.
- Reset: rst=0 sampled on an edge forces INST_ADDR and clears HALTED, regardless of current phase, stall, or halt.
- Outputs during reset: after the reset edge, outputs equal the INST_ADDR decode (sel=1, all else 0, halt=0, phase=0).
- Reset mid-instruction aborts the instruction; no wr or ld_ac is issued after the reset edge.
- Reset beats a simultaneous run or mem_rdy.
- Instruction length: 8 cycles with no stall; each stall cycle adds 1.

Optional Feature:
- Macro: CPU_CTRL_STEP_EN.
- When defined:
  - Adds input step (1 bit).
  - After STORE, the FSM enters a PAUSE state (outputs all 0, phase=INST_ADDR encoding, halt=0) and stays there until step=1.
  - It then goes to INST_ADDR on the next edge, so one instruction executes per step pulse.
  - HLT still goes to HALTED; step does not release HALTED.
  - Reset clears PAUSE.
- When not defined: no step port; STORE goes directly to INST_ADDR.

Test Plan:
1. Reset, then LDA (opcode=5) with mem_rdy=1 → phases 0..7 in 8 cycles; ld_ir=1 in phases 2-3; inc_pc=1 in phase 4; ld_ac=1 only in phase 7; wr=0 throughout.
2. STO (opcode=6) → data_e=1 in phases 6-7; wr=1 only in phase 7; rd=0 in phases 5-7.
3. SKZ with zero=1 → inc_pc=1 in phases 4 and 6 (2 increments). SKZ with zero=0 → inc_pc=1 in phase 4 only. JMP → ld_pc=1 in phases 6-7, inc_pc=1 in phase 4 only.
4. HLT (opcode=0) → halt=1 in phase 4, then HALTED with halt held high for 10 idle cycles; run pulse → phase=0 and halt=0 the next cycle; a run pulse while running has no effect.
5. mem_rdy=0 for 3 cycles in INST_FETCH and for 2 cycles in OP_FETCH (ADD) → phase held with rd=1; instruction takes 13 cycles. With STALL_EN=0 the same stimulus gives 8 cycles.
6. rst=0 asserted during STORE of STO, and separately during HALTED → next cycle phase=0, wr=0, halt=0, sel=1.

Source files
------------

// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm - sequencing controller for the 5-bit-address accumulator CPU.
//
// Steps each instruction through eight phases (instruction address/fetch/load,
// idle, operand address/fetch, ALU op, store), handles HLT/SKZ/JMP control flow
// and optionally stalls the two fetch phases on slow memory.
//
// Parameters:
//   STALL_EN  1 = hold INST_FETCH / OP_FETCH while mem_rdy is low,
//             0 = mem_rdy ignored (single-cycle memory)
//
// Optional build macro:
//   CPU_CTRL_STEP_EN  adds input 'step'; after STORE the FSM parks in PAUSE
//                     until step=1, giving one instruction per step pulse.
//
// Ports:
//   clk      in   system clock, all state changes on the rising edge
//   rst      in   synchronous active-low reset
//   opcode   in   [2:0] instruction opcode (IR[7:5])
//   zero     in   accumulator-zero flag
//   mem_rdy  in   memory data valid, used only in the fetch phases
//   run      in   pulse that resumes execution from HALTED
//   step     in   (CPU_CTRL_STEP_EN only) releases PAUSE
//   sel      out  address mux select, 1 = PC, 0 = IR operand
//   rd       out  memory read enable
//   ld_ir    out  load instruction register
//   inc_pc   out  PC increment enable
//   ld_pc    out  PC parallel load
//   ld_ac    out  load accumulator
//   wr       out  memory write strobe
//   data_e   out  accumulator drives data bus
//   halt     out  high while halted
//   phase    out  [2:0] current phase for debug/trace

module cpu_ctrl_fsm #(
    parameter int unsigned STALL_EN = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] opcode,
    input  logic       zero,
    input  logic       mem_rdy,
    input  logic       run,
`ifdef CPU_CTRL_STEP_EN
    input  logic       step,
`endif
    output logic       sel,
    output logic       rd,
    output logic       ld_ir,
    output logic       inc_pc,
    output logic       ld_pc,
    output logic       ld_ac,
    output logic       wr,
    output logic       data_e,
    output logic       halt,
    output logic [2:0] phase
);

    localparam logic [2:0] OpHlt = 3'd0;
    localparam logic [2:0] OpSkz = 3'd1;
    localparam logic [2:0] OpAdd = 3'd2;
    localparam logic [2:0] OpAnd = 3'd3;
    localparam logic [2:0] OpXor = 3'd4;
    localparam logic [2:0] OpLda = 3'd5;
    localparam logic [2:0] OpSto = 3'd6;
    localparam logic [2:0] OpJmp = 3'd7;

    // Phase states use their phase number as encoding so phase = state[2:0].
    typedef enum logic [3:0] {
        StInstAddr  = 4'd0,
        StInstFetch = 4'd1,
        StInstLoad  = 4'd2,
        StIdle      = 4'd3,
        StOpAddr    = 4'd4,
        StOpFetch   = 4'd5,
        StAluOp     = 4'd6,
        StStore     = 4'd7,
        StHalted    = 4'd8,
        StPause     = 4'd9
    } state_e;

    state_e state_q;
    logic   mem_wait;
    logic   alu_op;

    assign mem_wait = (STALL_EN != 0) && !mem_rdy;
    assign alu_op   = (opcode == OpAdd) || (opcode == OpAnd) ||
                      (opcode == OpXor) || (opcode == OpLda);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StInstAddr;
        end else begin
            case (state_q)
                StInstAddr:  state_q <= StInstFetch;
                StInstFetch: if (!mem_wait) state_q <= StInstLoad;
                StInstLoad:  state_q <= StIdle;
                StIdle:      state_q <= StOpAddr;
                StOpAddr:    state_q <= (opcode == OpHlt) ? StHalted : StOpFetch;
                StOpFetch:   if (!mem_wait) state_q <= StAluOp;
                StAluOp:     state_q <= StStore;
`ifdef CPU_CTRL_STEP_EN
                StStore:     state_q <= StPause;
                StPause:     if (step) state_q <= StInstAddr;
`else
                StStore:     state_q <= StInstAddr;
`endif
                StHalted:    if (run) state_q <= StInstAddr;
                default:     state_q <= StInstAddr;
            endcase
        end
    end

    // Outputs decode (state, opcode, zero) combinationally.
    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        ld_pc  = 1'b0;
        ld_ac  = 1'b0;
        wr     = 1'b0;
        data_e = 1'b0;
        halt   = 1'b0;
        phase  = state_q[2:0];
        case (state_q)
            StInstAddr: begin
                sel = 1'b1;
            end
            StInstFetch: begin
                sel = 1'b1;
                rd  = 1'b1;
            end
            StInstLoad, StIdle: begin
                sel   = 1'b1;
                rd    = 1'b1;
                ld_ir = 1'b1;
            end
            StOpAddr: begin
                inc_pc = 1'b1;
                halt   = (opcode == OpHlt);
            end
            StOpFetch: begin
                rd = alu_op;
            end
            StAluOp: begin
                rd     = alu_op;
                inc_pc = (opcode == OpSkz) && zero;
                ld_pc  = (opcode == OpJmp);
                data_e = (opcode == OpSto);
            end
            StStore: begin
                rd     = alu_op;
                ld_ac  = alu_op;
                ld_pc  = (opcode == OpJmp);
                wr     = (opcode == OpSto);
                data_e = (opcode == OpSto);
            end
            StHalted: begin
                halt  = 1'b1;
                phase = 3'd4;
            end
            default: begin
                // PAUSE (and any unreachable code): all strobes off
                phase = 3'd0;
            end
        endcase
    end

endmodule
